// File: rtl/srm_pkg.sv
// Shared types and encodings for the srm_ctrl register-transfer sequencer.
package srm_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_AW = 3;

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_WRITE_IMM = 3'd2,
      S_GET_A     = 3'd3,
      S_GET_B     = 3'd4,
      S_EXEC      = 3'd5,
      S_WRITE_REG = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CLS_NOP     = 3'd0,
      CLS_MOV_IMM = 3'd1,
      CLS_MOV_REG = 3'd2,
      CLS_MVN     = 3'd3,
      CLS_ADD     = 3'd4,
      CLS_CMP     = 3'd5,
      CLS_AND     = 3'd6
   } instr_cls_t;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   localparam logic [1:0] VSEL_C   = 2'b00;
   localparam logic [1:0] VSEL_IMM = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;

endpackage

// File: rtl/srm_ir_decode.sv
// Combinational instruction-register decode: fields, sign-extended immediates, class.
module srm_ir_decode
   import srm_pkg::*;
(
   input  logic [DATA_W-1:0] ir,
   output logic [REG_AW-1:0] rn,
   output logic [REG_AW-1:0] rd,
   output logic [REG_AW-1:0] rm,
   output logic [1:0]        sh,
   output logic [DATA_W-1:0] sximm8,
   output logic [DATA_W-1:0] sximm5,
   output instr_cls_t        cls
);

   logic [2:0] opcode;
   logic [1:0] op;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];
   assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
   assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};

   // Anything outside the supported opcode/op pairs collapses to CLS_NOP.
   always_comb begin
      cls = CLS_NOP;
      if (opcode == OPC_MOV) begin
         if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
         else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
      end else if (opcode == OPC_ALU) begin
         case (op)
            OP_ADD:  cls = CLS_ADD;
            OP_CMP:  cls = CLS_CMP;
            OP_AND:  cls = CLS_AND;
            default: cls = CLS_MVN;
         endcase
      end
   end

endmodule

// File: rtl/srm_ctrl.sv
// Register-file/datapath sequencer: one register transfer per cycle, Moore outputs.
// Optional SRM_CTRL_ILLEGAL_EN adds a sticky `illegal` flag that blocks new starts.
module srm_ctrl
   import srm_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in,
   input  logic              load,
   input  logic              s,
   output logic              w,
   output logic [REG_AW-1:0] readnum,
   output logic [REG_AW-1:0] writenum,
   output logic              write,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic              bsel,
   output logic [1:0]        vsel,
   output logic [1:0]        shift,
   output logic [1:0]        ALUop,
   output logic [DATA_W-1:0] sximm8,
   output logic [DATA_W-1:0] sximm5
`ifdef SRM_CTRL_ILLEGAL_EN
   ,
   output logic              illegal
`endif
);

   state_t            state;
   state_t            state_nx;
   logic [DATA_W-1:0] ir;
   logic [REG_AW-1:0] rn;
   logic [REG_AW-1:0] rd;
   logic [REG_AW-1:0] rm;
   logic [1:0]        sh;
   instr_cls_t        cls;
   logic              start;

   srm_ir_decode u_dec (
      .ir     (ir),
      .rn     (rn),
      .rd     (rd),
      .rm     (rm),
      .sh     (sh),
      .sximm8 (sximm8),
      .sximm5 (sximm5),
      .cls    (cls)
   );

`ifdef SRM_CTRL_ILLEGAL_EN
   always_ff @(posedge clk) begin
      if (!reset_n)
         illegal <= 1'b0;
      else if (state == S_DECODE && cls == CLS_NOP)
         illegal <= 1'b1;
   end

   assign start = s & ~illegal;
`else
   assign start = s;
`endif

   // IR only moves in WAIT, so a same-cycle load+s is seen by DECODE.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_WAIT;
         ir    <= '0;
      end else begin
         state <= state_nx;
         if (state == S_WAIT && load)
            ir <= in;
      end
   end

   always_comb begin
      state_nx = state;
      w        = 1'b0;
      readnum  = '0;
      writenum = '0;
      write    = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      vsel     = VSEL_C;
      shift    = 2'b00;
      ALUop    = ALU_ADD;
      case (state)
         S_WAIT: begin
            w = 1'b1;
            if (start) state_nx = S_DECODE;
         end
         S_DECODE: begin
            case (cls)
               CLS_MOV_IMM:                   state_nx = S_WRITE_IMM;
               CLS_MOV_REG, CLS_MVN:          state_nx = S_GET_B;
               CLS_ADD, CLS_CMP, CLS_AND:     state_nx = S_GET_A;
               default:                       state_nx = S_WAIT;
            endcase
         end
         S_WRITE_IMM: begin
            writenum = rn;
            vsel     = VSEL_IMM;
            write    = 1'b1;
            state_nx = S_WAIT;
         end
         S_GET_A: begin
            readnum  = rn;
            loada    = 1'b1;
            state_nx = S_GET_B;
         end
         S_GET_B: begin
            readnum  = rm;
            loadb    = 1'b1;
            state_nx = S_EXEC;
         end
         S_EXEC: begin
            shift    = sh;
            state_nx = S_WRITE_REG;
            case (cls)
               CLS_MOV_REG: begin
                  asel  = 1'b1;
                  loadc = 1'b1;
               end
               CLS_MVN: begin
                  ALUop = ALU_MVN;
                  loadc = 1'b1;
               end
               CLS_AND: begin
                  ALUop = ALU_AND;
                  loadc = 1'b1;
               end
               CLS_CMP: begin
                  ALUop    = ALU_SUB;
                  loads    = 1'b1;
                  state_nx = S_WAIT;
               end
               default: begin
                  loadc = 1'b1;
               end
            endcase
         end
         S_WRITE_REG: begin
            writenum = rd;
            vsel     = VSEL_C;
            write    = 1'b1;
            state_nx = S_WAIT;
         end
         default: state_nx = S_WAIT;
      endcase
      // The reset edge must never disturb the register file or datapath.
      if (!reset_n) begin
         write = 1'b0;
         loada = 1'b0;
         loadb = 1'b0;
         loadc = 1'b0;
         loads = 1'b0;
      end
   end

endmodule

// File: tb/tb_srm_ctrl.sv
// Scoreboard bench for srm_ctrl: per-cycle expected outputs from an instruction-level model.
module tb_srm_ctrl;

   typedef struct packed {
      logic        ill;
      logic        w;
      logic [2:0]  readnum;
      logic [2:0]  writenum;
      logic        write;
      logic        loada;
      logic        loadb;
      logic        loadc;
      logic        loads;
      logic        asel;
      logic        bsel;
      logic [1:0]  vsel;
      logic [1:0]  shift;
      logic [1:0]  aluop;
      logic [15:0] sximm8;
      logic [15:0] sximm5;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] in_w;
   logic        load;
   logic        s;
   logic        w;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic        write;
   logic        loada, loadb, loadc, loads, asel, bsel;
   logic [1:0]  vsel, shift, alu_op;
   logic [15:0] sximm8, sximm5;
   logic        ill_act;

   always #5 clk = ~clk;

   srm_ctrl dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in       (in_w),
      .load     (load),
      .s        (s),
      .w        (w),
      .readnum  (readnum),
      .writenum (writenum),
      .write    (write),
      .loada    (loada),
      .loadb    (loadb),
      .loadc    (loadc),
      .loads    (loads),
      .asel     (asel),
      .bsel     (bsel),
      .vsel     (vsel),
      .shift    (shift),
      .ALUop    (alu_op),
      .sximm8   (sximm8),
      .sximm5   (sximm5)
`ifdef SRM_CTRL_ILLEGAL_EN
      ,
      .illegal  (ill_act)
`endif
   );

`ifndef SRM_CTRL_ILLEGAL_EN
   assign ill_act = 1'b0;
`endif

   rec_t        sb[$];
   rec_t        steps[$];
   logic [15:0] ir_m;
   logic        ill_m;
   int          n_cmp = 0;
   int          n_mis = 0;
   int          cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every cycle with a pending expectation is compared in full.
   always @(negedge clk) begin
      rec_t a, e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = '{ill_act, w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, alu_op, sximm8, sximm5};
         n_cmp++;
         if (a !== e) begin
            n_mis++;
            $display("FAIL outputs cyc=%0d actual=%h expected=%h", cyc, a, e);
         end
      end
   end

   function automatic rec_t base(input logic [15:0] ir);
      rec_t r = '0;
      r.sximm8 = {{8{ir[7]}}, ir[7:0]};
      r.sximm5 = {{11{ir[4]}}, ir[4:0]};
      r.ill    = ill_m;
      return r;
   endfunction

   function automatic rec_t wait_rec(input logic [15:0] ir);
      rec_t r = base(ir);
      r.w = 1'b1;
      return r;
   endfunction

   // Instruction-level model: the list of transfers one instruction performs.
   task automatic plan(input logic [15:0] ir);
      logic [2:0] opc = ir[15:13];
      logic [1:0] op  = ir[12:11];
      rec_t r;
      steps.delete();
      steps.push_back(base(ir));
      if (opc == 3'b110 && op == 2'b10) begin
         r = base(ir); r.writenum = ir[10:8]; r.vsel = 2'b10; r.write = 1'b1;
         steps.push_back(r);
      end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
         r = base(ir); r.readnum = ir[2:0]; r.loadb = 1'b1; steps.push_back(r);
         r = base(ir); r.shift = ir[4:3]; r.asel = (opc == 3'b110);
         r.aluop = (opc == 3'b110) ? 2'b00 : 2'b11; r.loadc = 1'b1; steps.push_back(r);
         r = base(ir); r.writenum = ir[7:5]; r.write = 1'b1; steps.push_back(r);
      end else if (opc == 3'b101) begin
         r = base(ir); r.readnum = ir[10:8]; r.loada = 1'b1; steps.push_back(r);
         r = base(ir); r.readnum = ir[2:0]; r.loadb = 1'b1; steps.push_back(r);
         r = base(ir); r.shift = ir[4:3]; r.aluop = op;
         r.loads = (op == 2'b01); r.loadc = (op != 2'b01); steps.push_back(r);
         if (op != 2'b01) begin
            r = base(ir); r.writenum = ir[7:5]; r.write = 1'b1; steps.push_back(r);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tick();
      reset_n = 1'b1; s = 1'b0; load = 1'($urandom); in_w = 16'($urandom);
      sb.push_back(wait_rec(ir_m));
      if (load) ir_m = in_w;
   endtask

   // Issue one instruction from a WAIT cycle; reset_at>=0 pulls reset on that step.
   task automatic run_instr(input logic [15:0] instr, input bit with_load, input int reset_at);
      rec_t r;
      bit   unsup;
      tick();
      reset_n = 1'b1; s = 1'b1; load = with_load; in_w = instr;
      sb.push_back(wait_rec(ir_m));
      if (with_load) ir_m = instr;
      if (ill_m) return;
      plan(ir_m);
      unsup = (steps.size() == 1);
      for (int i = 0; i < steps.size(); i++) begin
         tick();
         s = 1'($urandom); load = 1'($urandom); in_w = 16'($urandom);
         r = steps[i];
         if (i == reset_at) begin
            reset_n = 1'b0;
            r.write = 0; r.loada = 0; r.loadb = 0; r.loadc = 0; r.loads = 0;
            sb.push_back(r);
            ir_m  = '0;
            ill_m = 1'b0;
            return;
         end
         sb.push_back(r);
      end
`ifdef SRM_CTRL_ILLEGAL_EN
      if (unsup) ill_m = 1'b1;
`else
      if (unsup) ill_m = 1'b0;
`endif
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] x = 16'($urandom);
`ifdef SRM_CTRL_ILLEGAL_EN
      int k = $urandom_range(0, 5);
`else
      int k = $urandom_range(0, 6);
`endif
      case (k)
         0: x[15:11] = 5'b11010;
         1: x[15:11] = 5'b11000;
         2: x[15:11] = 5'b10111;
         3: x[15:11] = 5'b10100;
         4: x[15:11] = 5'b10101;
         5: x[15:11] = 5'b10110;
         default: ;
      endcase
      return x;
   endfunction

   initial begin
      reset_n = 1'b0; s = 1'b0; load = 1'b0; in_w = '0;
      ir_m = '0; ill_m = 1'b0;
      repeat (3) @(posedge clk);
      run_instr(16'hD007, 1'b1, -1);
      run_instr(16'hD1FE, 1'b1, -1);
      run_instr(16'hA148, 1'b1, -1);
      run_instr(16'hA900, 1'b1, -1);
      idle();
      run_instr(16'hA148, 1'b1, 4);
      idle();
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) idle();
         run_instr(rand_instr(), ($urandom_range(0, 4) != 0),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1);
      end
      run_instr(16'h0000, 1'b1, -1);
      for (int n = 0; n < 4; n++) run_instr(16'hD007, 1'b1, -1);
      idle();
      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         n_mis++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
